ps2_frame_ctrl: RTL and testbench
=================================

// Module: ps2_frame_ctrl
// PURPOSE
//   Receives PS/2 keyboard serial frames and sequences the combinational keycode decoder.
//   - Synchronises ps2_clk/ps2_data and shifts in 11-bit frames.
//   - Checks start, odd parity and stop bits; absorbs E0 (extended) and F0 (break) prefixes.
//   - Presents each checked frame, held stable, with a 1-cycle valid strobe.
//   - Sits between the keyboard pins and the decoder; frame output drives decoder input q.
// PARAMETERS
//   N            11     frame length in bits (start + 8 data + parity + stop)
//   TIMEOUT_CYC  5000   clk cycles without a ps2_clk falling edge before a partial frame is dropped
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   ps2_clk      in   1  raw PS/2 clock pin, asynchronous
//   ps2_data     in   1  raw PS/2 data pin, asynchronous
//   frame        out  N  last good frame; first-received bit (start) in [N-1], stop in [0]
//   frame_valid  out  1  1-cycle strobe: frame just updated with a non-prefix frame
//   key_release  out  1  qualifies frame: F0 preceded this code; valid while frame is held
//   key_ext      out  1  qualifies frame: E0 preceded this code; valid while frame is held
//   frame_err    out  1  1-cycle strobe: bad start/parity/stop, or timeout
//   busy         out  1  high while a frame is partially received
// BEHAVIOUR
//   Reset values (async, rst_n=0): all outputs 0; frame=0; FSM=IDLE; prefix flags, counters and sync flops cleared.
//   Input conditioning:
//   - ps2_clk and ps2_data each pass through 2-flop synchronisers.
//   - A falling edge is sync_clk 1->0 between consecutive clk cycles.
//   - Data is sampled from sync_data in the edge-detect cycle (equal sync delay on both pins).
//   FSM states: IDLE, RECV, CHECK.
//   - IDLE -> RECV: on a falling edge; shift in bit 1, bit_cnt=1, busy=1.
//   - RECV:
//     - Each falling edge shifts sync_data into shreg LSB (shreg <= {shreg[N-2:0], d}); bit_cnt++.
//     - bit_cnt reaching N -> CHECK.
//     - TIMEOUT_CYC cycles with no edge -> IDLE; frame_err=1 one cycle; prefix flags cleared; frame unchanged.
//   - CHECK (exactly 1 cycle, then IDLE):
//     - Good frame: shreg[N-1]=0, shreg[0]=1, and ^shreg[N-2:1]=1 (odd parity over data+parity).
//     - Data byte in wire order: d0=shreg[9] ... d7=shreg[2]; byte = {shreg[2],...,shreg[9]}.
//     - Good, byte=F0: set rel_pend; no frame_valid; frame unchanged.
//     - Good, byte=E0: set ext_pend; no frame_valid; frame unchanged.
//     - Good, other byte: on the next clk edge frame<=shreg, key_release<=rel_pend, key_ext<=ext_pend,
//       frame_valid=1 for one cycle; rel_pend and ext_pend cleared.
//     - Bad: frame_err=1 one cycle; rel_pend and ext_pend cleared; frame unchanged.
//   Latency: frame_valid and frame_err assert in the cycle after CHECK, i.e. 2 clk after the
//     11th edge-detect cycle (about 4-5 clk after the pin edge).
//   busy: 1 in RECV and CHECK, 0 in IDLE.
//   Timeout counter: resets on every falling edge; counts only in RECV; width $clog2(TIMEOUT_CYC+1).
//   Boundary cases:
//   - A falling edge during CHECK is ignored (physically impossible at PS/2 rates).
//   - F0 followed by E0: both flags set; order irrelevant.
//   - Repeated F0: rel_pend stays 1.
//   - rst_n asserted mid-frame: partial frame discarded; no strobe on release.
//   - Glitch-free requirement: frame, key_release and key_ext change only in the frame_valid cycle.
// STRUCTURE
//   Shared package ps2_pkg:
//   - localparam PS2_N=11, BRK_CODE=8'hF0, EXT_CODE=8'hE0.
//   - typedef enum logic [1:0] {IDLE,RECV,CHECK} ps2_state_t.
//   Sub-module ps2_sync_edge: 2-flop sync of both pins plus falling-edge detect.
//   - Outputs data_s and fall_pulse.
// TESTING
//   1. Send code 16 (d0..d7=0,1,1,0,1,0,0,0, par=0) -> frame=11'b00110100001, frame_valid 1 cycle,
//      key_release=0, key_ext=0, frame_err=0.
//   2. Send F0 (frame 11'b00000111111) then 16 -> one frame_valid only, for 16, with key_release=1, key_ext=0.
//   3. Send E0 (11'b00000011101), F0, 1D -> single frame_valid with key_ext=1, key_release=1;
//      the following code 1D alone gives both flags 0.
//   4. Send 16 with parity bit flipped -> frame_err 1 cycle, no frame_valid, frame keeps previous value.
//      Repeat with stop=0 and with start=1: same result.
//   5. Send 6 bits then idle for TIMEOUT_CYC+10 cycles -> frame_err 1 cycle, busy returns 0;
//      a following full code 1C is received correctly.
//   6. Pull rst_n low mid-frame (after 5 bits) -> all outputs 0 immediately, no strobes after release;
//      the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and state type for the PS/2 frame receiver
// Purpose : frame length, prefix codes and FSM state encoding used by ps2_frame_ctrl.
// Ports   : none (package).
package ps2_pkg;

    localparam int         PS2_N    = 11;
    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop pin synchroniser with ps2_clk falling-edge detect
// Purpose : bring the asynchronous PS/2 pins into the clk domain and flag ps2_clk falls.
// Ports   : clk, rst_n      - system clock, async active-low reset
//           ps2_clk         - raw PS/2 clock pin
//           ps2_data        - raw PS/2 data pin
//           data_s          - synchronised data, aligned with fall_pulse
//           fall_pulse      - 1-cycle pulse when synchronised ps2_clk goes 1->0
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall_pulse
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b00;
            data_sync <= 2'b00;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // Both pins see the same two-flop delay, so data_s is the bit that was
    // on the wire when ps2_clk fell.
    assign data_s     = data_sync[1];
    assign fall_pulse = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_frame_ctrl.sv
// rtl/ps2_frame_ctrl.sv - PS/2 keyboard frame receiver and decoder sequencer
// Purpose : shift in 11-bit PS/2 frames, check start/parity/stop, absorb E0/F0
//           prefixes and present each good keycode frame with a 1-cycle strobe.
// Ports   : clk, rst_n      - system clock, async active-low reset
//           ps2_clk/data    - raw PS/2 pins
//           frame           - last good frame, start bit in [N-1], stop in [0]
//           frame_valid     - 1-cycle strobe, frame just updated
//           key_release     - F0 preceded the held frame
//           key_ext         - E0 preceded the held frame
//           frame_err       - 1-cycle strobe on bad frame or timeout
//           busy            - frame partially received
module ps2_frame_ctrl
    import ps2_pkg::*;
#(
    parameter int N           = PS2_N,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [N-1:0] frame,
    output logic         frame_valid,
    output logic         key_release,
    output logic         key_ext,
    output logic         frame_err,
    output logic         busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic             data_s;
    logic             fall_pulse;
    ps2_state_t       state;
    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [TO_W-1:0]  tcnt;
    logic             rel_pend;
    logic             ext_pend;
    logic [7:0]       data_byte;
    logic             good;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_s     (data_s),
        .fall_pulse (fall_pulse)
    );

    // d0 arrives first after the start bit, so it sits just below the MSB.
    always_comb begin
        data_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            data_byte[i] = shreg[N-2-i];
        end
    end

    assign good = ~shreg[N-1] & shreg[0] & (^shreg[N-2:1]);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            tcnt        <= '0;
            rel_pend    <= 1'b0;
            ext_pend    <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            key_release <= 1'b0;
            key_ext     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_pulse) begin
                        shreg   <= {shreg[N-2:0], data_s};
                        bit_cnt <= CNT_W'(1);
                        tcnt    <= '0;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (fall_pulse) begin
                        shreg   <= {shreg[N-2:0], data_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        tcnt    <= '0;
                        if (bit_cnt == CNT_W'(N - 1)) begin
                            state <= CHECK;
                        end
                    end else if (tcnt == TO_W'(TIMEOUT_CYC)) begin
                        // Keyboard stalled mid-frame: drop it and any pending prefix.
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        rel_pend  <= 1'b0;
                        ext_pend  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!good) begin
                        frame_err <= 1'b1;
                        rel_pend  <= 1'b0;
                        ext_pend  <= 1'b0;
                    end else if (data_byte == BRK_CODE) begin
                        rel_pend <= 1'b1;
                    end else if (data_byte == EXT_CODE) begin
                        ext_pend <= 1'b1;
                    end else begin
                        frame       <= shreg;
                        key_release <= rel_pend;
                        key_ext     <= ext_pend;
                        frame_valid <= 1'b1;
                        rel_pend    <= 1'b0;
                        ext_pend    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// tb/tb_ps2_frame_ctrl.sv - self-checking bench for ps2_frame_ctrl
module tb_ps2_frame_ctrl;

    localparam int N           = 11;
    localparam int TIMEOUT_CYC = 5000;
    localparam int HALF        = 15;
    localparam int GAP         = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic [N-1:0] frame;
    logic         frame_valid;
    logic         key_release;
    logic         key_ext;
    logic         frame_err;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    // Observed event counts and glitch detector.
    int           valid_cnt = 0;
    int           err_cnt = 0;
    int           glitch_cnt = 0;
    logic [N+1:0] prev_held = '0;

    // Reference model state.
    int           exp_valid = 0;
    int           exp_err = 0;
    logic [N-1:0] exp_frame = '0;
    logic         exp_rel = 1'b0;
    logic         exp_ext = 1'b0;
    logic         m_rel = 1'b0;
    logic         m_ext = 1'b0;

    ps2_frame_ctrl #(.N(N), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .frame       (frame),
        .frame_valid (frame_valid),
        .key_release (key_release),
        .key_ext     (key_ext),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) valid_cnt <= valid_cnt + 1;
            if (frame_err)   err_cnt   <= err_cnt + 1;
            if (!frame_valid && ({frame, key_release, key_ext} !== prev_held))
                glitch_cnt <= glitch_cnt + 1;
        end
        prev_held <= {frame, key_release, key_ext};
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Wire-order frame: start, d0..d7, odd parity, stop. kind 1/2/3 corrupt parity/stop/start.
    function automatic logic [N-1:0] mk_frame(input logic [7:0] b, input int kind);
        logic [N-1:0] f;
        int ones;
        ones = 0;
        f[N-1] = (kind == 3);
        for (int i = 0; i < 8; i++) begin
            f[N-2-i] = b[i];
            ones += int'(b[i]);
        end
        f[1] = ((ones % 2) == 0) ^ (kind == 1);
        f[0] = (kind != 2);
        return f;
    endfunction

    task automatic send_bits(input logic [N-1:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[N-1-i];
            repeat (HALF) @(posedge clk);
            #2 ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #2 ps2_clk = 1'b1;
        end
    endtask

    task automatic model_apply(input logic [7:0] b, input int kind);
        if (kind != 0) begin
            exp_err++;
            m_rel = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            exp_valid++;
            exp_frame = mk_frame(b, 0);
            exp_rel   = m_rel;
            exp_ext   = m_ext;
            m_rel = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind);
        send_bits(mk_frame(b, kind), N);
        ps2_data = 1'b1;
        model_apply(b, kind);
        repeat (GAP) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({frame, frame_valid, key_release, key_ext, frame_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got frame=%b v=%b rel=%b ext=%b err=%b busy=%b want all 0",
                     frame, frame_valid, key_release, key_ext, frame_err, busy);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({frame, frame_valid, frame_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle got frame=%b v=%b err=%b busy=%b want 0", frame, frame_valid, frame_err, busy);
        end
    endtask

    task automatic test_basic_code();
        send_byte(8'h16, 0);
        vectors++;
        if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
            miscompares++;
            $display("FAIL basic_16 got v=%0d e=%0d frame=%b rel=%b ext=%b want v=%0d e=%0d frame=%b rel=%b ext=%b",
                     valid_cnt, err_cnt, frame, key_release, key_ext, exp_valid, exp_err, exp_frame, exp_rel, exp_ext);
        end
        vectors++;
        if (frame !== 11'b00110100001) begin
            miscompares++;
            $display("FAIL basic_16_literal got %b want 00110100001", frame);
        end
    endtask

    task automatic test_break_prefix();
        send_byte(8'hF0, 0);
        send_byte(8'h16, 0);
        vectors++;
        if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
            miscompares++;
            $display("FAIL break_16 got v=%0d e=%0d frame=%b rel=%b ext=%b want v=%0d e=%0d frame=%b rel=%b ext=%b",
                     valid_cnt, err_cnt, frame, key_release, key_ext, exp_valid, exp_err, exp_frame, exp_rel, exp_ext);
        end
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h1D, 0);
        vectors++;
        if ({valid_cnt, frame, key_release, key_ext} !== {exp_valid, exp_frame, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL ext_break_1d got v=%0d frame=%b rel=%b ext=%b want v=%0d frame=%b rel=1 ext=1",
                     valid_cnt, frame, key_release, key_ext, exp_valid, exp_frame);
        end
        send_byte(8'h1D, 0);
        vectors++;
        if ({valid_cnt, frame, key_release, key_ext} !== {exp_valid, exp_frame, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL plain_1d got v=%0d frame=%b rel=%b ext=%b want v=%0d frame=%b rel=0 ext=0",
                     valid_cnt, frame, key_release, key_ext, exp_valid, exp_frame);
        end
    endtask

    task automatic test_bad_frames();
        for (int k = 1; k <= 3; k++) begin
            send_byte(8'h16, k);
            vectors++;
            if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
                miscompares++;
                $display("FAIL bad_kind%0d got v=%0d e=%0d frame=%b want v=%0d e=%0d frame=%b",
                         k, valid_cnt, err_cnt, frame, exp_valid, exp_err, exp_frame);
            end
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hF0, 0);
        send_bits(mk_frame(8'h1C, 0), 6);
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_busy_mid got %b want 1", busy);
        end
        repeat (TIMEOUT_CYC + 10) @(posedge clk);
        @(negedge clk);
        exp_err++;
        m_rel = 1'b0;
        m_ext = 1'b0;
        vectors++;
        if ({valid_cnt, err_cnt, busy} !== {exp_valid, exp_err, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_err got v=%0d e=%0d busy=%b want v=%0d e=%0d busy=0",
                     valid_cnt, err_cnt, busy, exp_valid, exp_err);
        end
        send_byte(8'h1C, 0);
        vectors++;
        if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
            miscompares++;
            $display("FAIL timeout_then_1c got v=%0d e=%0d frame=%b rel=%b want v=%0d e=%0d frame=%b rel=%b",
                     valid_cnt, err_cnt, frame, key_release, exp_valid, exp_err, exp_frame, exp_rel);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hE0, 0);
        send_bits(mk_frame(8'h2A, 0), 5);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({frame, frame_valid, key_release, key_ext, frame_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got frame=%b v=%b rel=%b ext=%b err=%b busy=%b want all 0",
                     frame, frame_valid, key_release, key_ext, frame_err, busy);
        end
        ps2_data = 1'b1;
        exp_frame = '0;
        exp_rel = 1'b0;
        exp_ext = 1'b0;
        m_rel = 1'b0;
        m_ext = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (GAP + 10) @(negedge clk);
        vectors++;
        if ({valid_cnt, err_cnt, busy} !== {exp_valid, exp_err, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_no_strobe got v=%0d e=%0d busy=%b want v=%0d e=%0d busy=0",
                     valid_cnt, err_cnt, busy, exp_valid, exp_err);
        end
        send_byte(8'h2A, 0);
        vectors++;
        if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
            miscompares++;
            $display("FAIL midreset_next got v=%0d e=%0d frame=%b ext=%b want v=%0d e=%0d frame=%b ext=%b",
                     valid_cnt, err_cnt, frame, key_ext, exp_valid, exp_err, exp_frame, exp_ext);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         kind;
        int         r;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      b = 8'hF0;
            else if (r < 24) b = 8'hE0;
            else             b = 8'($urandom);
            kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            send_byte(b, kind);
            vectors++;
            if ({valid_cnt, err_cnt, frame, key_release, key_ext} !== {exp_valid, exp_err, exp_frame, exp_rel, exp_ext}) begin
                miscompares++;
                $display("FAIL random_%0d byte=%h kind=%0d got v=%0d e=%0d frame=%b rel=%b ext=%b want v=%0d e=%0d frame=%b rel=%b ext=%b",
                         n, b, kind, valid_cnt, err_cnt, frame, key_release, key_ext,
                         exp_valid, exp_err, exp_frame, exp_rel, exp_ext);
            end
        end
    endtask

    task automatic test_glitch_free();
        vectors++;
        if (glitch_cnt !== 0) begin
            miscompares++;
            $display("FAIL glitch_free got %0d changes outside frame_valid want 0", glitch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_code();
        test_break_prefix();
        test_ext_break();
        test_bad_frames();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        test_glitch_free();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
